// File: rtl/proc_fl_iobuf.sv
// proc_fl_iobuf: buffered I/O bridge between the FP processor I/O port and
// per-channel valid/ready streams. Each input address owns a receive FIFO and
// each output address owns a transmit FIFO, with sticky underflow/overflow flags.
module proc_fl_iobuf #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4,
    localparam int NBDATA = NBMANT + NBEXPO + 1,
    localparam int AIW    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AOW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AIW-1:0]           proc_addr_in,
    input  logic                     proc_req_in,
    output logic [NBDATA-1:0]        proc_data_in,
    input  logic [AOW-1:0]           proc_addr_out,
    input  logic                     proc_out_en,
    input  logic [NBDATA-1:0]        proc_data_out,
    input  logic [NUIOIN*NBDATA-1:0] in_data,
    input  logic [NUIOIN-1:0]        in_valid,
    output logic [NUIOIN-1:0]        in_ready,
    output logic [NUIOOU*NBDATA-1:0] out_data,
    output logic [NUIOOU-1:0]        out_valid,
    input  logic [NUIOOU-1:0]        out_ready,
    output logic [NUIOIN-1:0]        in_under,
    output logic [NUIOOU-1:0]        out_over,
    input  logic                     clr_flags
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FDEPTH);

    logic [NBDATA-1:0] r_rx_mem [NUIOIN][FDEPTH];
    logic [PW-1:0]     r_rx_rp  [NUIOIN];
    logic [PW-1:0]     r_rx_wp  [NUIOIN];
    logic [CW-1:0]     r_rx_cnt [NUIOIN];
    logic [NBDATA-1:0] r_hold   [NUIOIN];
    logic [NUIOIN-1:0] r_in_under;

    logic [NBDATA-1:0] r_tx_mem [NUIOOU][FDEPTH];
    logic [PW-1:0]     r_tx_rp  [NUIOOU];
    logic [PW-1:0]     r_tx_wp  [NUIOOU];
    logic [CW-1:0]     r_tx_cnt [NUIOOU];
    logic [NUIOOU-1:0] r_out_over;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [NUIOIN-1:0] w_rd_sel;
    logic [NUIOIN-1:0] w_rx_push;
    logic [NUIOIN-1:0] w_rx_pop;
    logic [NUIOIN-1:0] w_rx_under;
    logic [NUIOOU-1:0] w_wr_sel;
    logic [NUIOOU-1:0] w_tx_push;
    logic [NUIOOU-1:0] w_tx_pop;
    logic [NUIOOU-1:0] w_tx_over;

    // Out-of-range addresses only exist for non-power-of-two channel counts.
    assign w_rd_ok = 32'(proc_addr_in) < 32'(NUIOIN);
    assign w_wr_ok = 32'(proc_addr_out) < 32'(NUIOOU);

    // Flags read as 0 while reset is held, before the first reset edge clears them.
    assign in_under = r_in_under & {NUIOIN{~rst}};
    assign out_over = r_out_over & {NUIOOU{~rst}};

    // Receive-side handshake, processor read decode and combinational read data.
    always_comb begin
        proc_data_in = '0;
        for (int c = 0; c < NUIOIN; c++) begin
            in_ready[c]   = (r_rx_cnt[c] < FULL) & ~rst;
            w_rx_push[c]  = in_valid[c] & in_ready[c];
            w_rd_sel[c]   = proc_req_in & w_rd_ok & ~rst & (proc_addr_in == AIW'(c));
            w_rx_pop[c]   = w_rd_sel[c] & (r_rx_cnt[c] != '0);
            w_rx_under[c] = w_rd_sel[c] & (r_rx_cnt[c] == '0);
        end
        if (!rst && w_rd_ok) begin
            // Empty channel shows the last word popped from it.
            proc_data_in = (r_rx_cnt[proc_addr_in] != '0)
                         ? r_rx_mem[proc_addr_in][r_rx_rp[proc_addr_in]]
                         : r_hold[proc_addr_in];
        end
    end

    // Transmit-side handshake and write acceptance; a full FIFO popping this cycle still accepts.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            out_valid[k] = (r_tx_cnt[k] != '0) & ~rst;
            w_tx_pop[k]  = out_valid[k] & out_ready[k];
            w_wr_sel[k]  = proc_out_en & w_wr_ok & ~rst & (proc_addr_out == AOW'(k));
            w_tx_push[k] = w_wr_sel[k] & ((r_tx_cnt[k] < FULL) | w_tx_pop[k]);
            w_tx_over[k] = w_wr_sel[k] & ~w_tx_push[k];
            out_data[k*NBDATA +: NBDATA] = r_tx_mem[k][r_tx_rp[k]];
        end
    end

    // FIFO storage writes; contents need no reset since counts gate visibility.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUIOIN; c++) begin
            if (w_rx_push[c]) r_rx_mem[c][r_rx_wp[c]] <= in_data[c*NBDATA +: NBDATA];
        end
        for (int k = 0; k < NUIOOU; k++) begin
            if (w_tx_push[k]) r_tx_mem[k][r_tx_wp[k]] <= proc_data_out;
        end
    end

    // Receive pointers, counts, hold registers and underflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUIOIN; c++) begin
                r_rx_rp[c]  <= '0;
                r_rx_wp[c]  <= '0;
                r_rx_cnt[c] <= '0;
                r_hold[c]   <= '0;
            end
            r_in_under <= '0;
        end else begin
            for (int c = 0; c < NUIOIN; c++) begin
                if (w_rx_push[c]) r_rx_wp[c] <= r_rx_wp[c] + 1'b1;
                if (w_rx_pop[c]) begin
                    r_rx_rp[c] <= r_rx_rp[c] + 1'b1;
                    r_hold[c]  <= r_rx_mem[c][r_rx_rp[c]];
                end
                r_rx_cnt[c] <= r_rx_cnt[c] + CW'(w_rx_push[c]) - CW'(w_rx_pop[c]);
            end
            // Set wins over clear.
            r_in_under <= (r_in_under & ~{NUIOIN{clr_flags}}) | w_rx_under;
        end
    end

    // Transmit pointers, counts and overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUIOOU; k++) begin
                r_tx_rp[k]  <= '0;
                r_tx_wp[k]  <= '0;
                r_tx_cnt[k] <= '0;
            end
            r_out_over <= '0;
        end else begin
            for (int k = 0; k < NUIOOU; k++) begin
                if (w_tx_push[k]) r_tx_wp[k] <= r_tx_wp[k] + 1'b1;
                if (w_tx_pop[k])  r_tx_rp[k] <= r_tx_rp[k] + 1'b1;
                r_tx_cnt[k] <= r_tx_cnt[k] + CW'(w_tx_push[k]) - CW'(w_tx_pop[k]);
            end
            r_out_over <= (r_out_over & ~{NUIOOU{clr_flags}}) | w_tx_over;
        end
    end

endmodule

// File: tb/tb_proc_fl_iobuf.sv
// tb_proc_fl_iobuf: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the bridge.
module tb_proc_fl_iobuf;

    localparam int ND = 23;
    localparam int NI = 8;
    localparam int NO = 8;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        proc_addr_in;
    logic              proc_req_in;
    logic [ND-1:0]     proc_data_in;
    logic [2:0]        proc_addr_out;
    logic              proc_out_en;
    logic [ND-1:0]     proc_data_out;
    logic [NI*ND-1:0]  in_data;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [NO*ND-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NI-1:0]     in_under;
    logic [NO-1:0]     out_over;
    logic              clr_flags;

    proc_fl_iobuf dut (
        .clk          (clk),
        .rst          (rst),
        .proc_addr_in (proc_addr_in),
        .proc_req_in  (proc_req_in),
        .proc_data_in (proc_data_in),
        .proc_addr_out(proc_addr_out),
        .proc_out_en  (proc_out_en),
        .proc_data_out(proc_data_out),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_under     (in_under),
        .out_over     (out_over),
        .clr_flags    (clr_flags)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [ND-1:0] rxq [NI][$];
    logic [ND-1:0] txq [NO][$];
    logic [ND-1:0] m_hold [NI];
    logic [NI-1:0] m_under;
    logic [NO-1:0] m_over;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs with the model, away from the rising edge.
    task automatic settle();
        logic [NI-1:0] e_ready;
        logic [NO-1:0] e_valid;
        logic [ND-1:0] e_pdi;
        @(negedge clk);
        for (int c = 0; c < NI; c++) e_ready[c] = !rst && rxq[c].size() < FD;
        for (int k = 0; k < NO; k++) e_valid[k] = !rst && txq[k].size() != 0;
        if (rst) e_pdi = '0;
        else if (rxq[proc_addr_in].size() > 0) e_pdi = rxq[proc_addr_in][0];
        else e_pdi = m_hold[proc_addr_in];
        check("in_ready", in_ready, e_ready);
        check("out_valid", out_valid, e_valid);
        check("proc_data_in", proc_data_in, e_pdi);
        check("in_under", in_under, rst ? '0 : m_under);
        check("out_over", out_over, rst ? '0 : m_over);
        for (int k = 0; k < NO; k++)
            if (!rst && txq[k].size() > 0) check("out_data", out_data[k*ND +: ND], txq[k][0]);
    endtask

    // Apply the current inputs to the model, then advance past the rising edge.
    task automatic tick();
        logic [NI-1:0] acc;
        logic [NO-1:0] tpop;
        int a;
        if (rst) begin
            for (int c = 0; c < NI; c++) begin rxq[c].delete(); m_hold[c] = '0; end
            for (int k = 0; k < NO; k++) txq[k].delete();
            m_under = '0;
            m_over  = '0;
        end else begin
            if (clr_flags) begin m_under = '0; m_over = '0; end
            for (int c = 0; c < NI; c++) acc[c] = in_valid[c] && rxq[c].size() < FD;
            a = int'(proc_addr_in);
            if (proc_req_in) begin
                if (rxq[a].size() > 0) m_hold[a] = rxq[a].pop_front();
                else m_under[a] = 1'b1;
            end
            for (int c = 0; c < NI; c++) if (acc[c]) rxq[c].push_back(in_data[c*ND +: ND]);
            for (int k = 0; k < NO; k++) tpop[k] = txq[k].size() > 0 && out_ready[k];
            a = int'(proc_addr_out);
            if (proc_out_en) begin
                if (txq[a].size() < FD || tpop[a]) begin
                    if (tpop[a]) void'(txq[a].pop_front());
                    tpop[a] = 1'b0;
                    txq[a].push_back(proc_data_out);
                end else begin
                    m_over[a] = 1'b1;
                end
            end
            for (int k = 0; k < NO; k++) if (tpop[k]) void'(txq[k].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        proc_req_in = 0; proc_out_en = 0; in_valid = '0; out_ready = '0; clr_flags = 0;
    endtask

    logic [ND-1:0] va [5];
    logic [ND-1:0] vw [6];

    initial begin
        for (int c = 0; c < NI; c++) m_hold[c] = '0;
        m_under = '0; m_over = '0;
        rst = 1; proc_addr_in = 0; proc_addr_out = 0; proc_data_out = '0; in_data = '0;
        idle_inputs();
        for (int i = 0; i < 5; i++) va[i] = ND'(32'h0A0001 + i);
        for (int i = 0; i < 6; i++) vw[i] = ND'(32'h3B0010 + i);
        cyc(); cyc();
        rst = 0;
        cyc();

        // Fill receive channel 2 with a stalled producer, then drain it.
        in_valid[2] = 1;
        for (int i = 0; i < 4; i++) begin in_data[2*ND +: ND] = va[i]; cyc(); end
        in_data[2*ND +: ND] = va[4];
        proc_addr_in = 2; proc_req_in = 1;
        settle();
        check("t1_full_ready", in_ready[2], 0);
        check("t1_rd0", proc_data_in, va[0]);
        tick();
        settle();
        check("t1_ready_back", in_ready[2], 1);
        check("t1_rd1", proc_data_in, va[1]);
        tick();
        in_valid[2] = 0;
        for (int i = 2; i < 5; i++) begin
            settle();
            check("t1_rdn", proc_data_in, va[i]);
            tick();
        end
        proc_req_in = 0;

        // Underflow on channel 5 returns the held word; clear and set-wins.
        in_data[5*ND +: ND] = ND'(32'h1234); in_valid[5] = 1; cyc(); in_valid[5] = 0;
        proc_addr_in = 5; proc_req_in = 1; cyc();
        settle();
        check("t2_hold", proc_data_in, ND'(32'h1234));
        tick();
        check("t2_under_set", in_under[5], 1);
        proc_req_in = 0; clr_flags = 1; cyc();
        check("t2_under_clr", in_under[5], 0);
        proc_req_in = 1; cyc();
        check("t2_set_wins", in_under[5], 1);
        proc_req_in = 0; clr_flags = 1; cyc(); clr_flags = 0;

        // Transmit overflow on channel 3, then a full write rescued by a same-cycle pop.
        proc_addr_out = 3; proc_out_en = 1;
        for (int i = 0; i < 5; i++) begin proc_data_out = vw[i]; cyc(); end
        check("t3_over", out_over[3], 1);
        proc_out_en = 0; clr_flags = 1; cyc(); clr_flags = 0;
        proc_out_en = 1; proc_data_out = vw[5]; out_ready[3] = 1; cyc();
        check("t3_no_over", out_over[3], 0);
        proc_out_en = 0; out_ready = '0;
        settle();
        check("t3_head", out_data[3*ND +: ND], vw[1]);
        tick();
        out_ready = '1;
        for (int i = 0; i < 5; i++) cyc();
        out_ready = '0;

        // Read and push a full receive channel in the same cycle.
        in_valid[1] = 1;
        for (int i = 0; i < 4; i++) begin in_data[1*ND +: ND] = va[i] ^ 23'h7F0000; cyc(); end
        in_data[1*ND +: ND] = 23'h55AA55;
        proc_addr_in = 1; proc_req_in = 1;
        settle();
        check("t4_refused", in_ready[1], 0);
        tick();
        in_valid[1] = 0;
        for (int i = 1; i < 4; i++) begin
            settle();
            check("t4_rd", proc_data_in, va[i] ^ 23'h7F0000);
            tick();
        end
        settle();
        check("t4_empty_hold", proc_data_in, va[3] ^ 23'h7F0000);
        tick();
        idle_inputs();

        // Reset with data queued on out channel 0 and in channel 1.
        rst = 1; cyc(); rst = 0;
        proc_addr_out = 0; proc_out_en = 1; in_valid[1] = 1;
        for (int i = 0; i < 3; i++) begin
            proc_data_out = vw[i]; in_data[1*ND +: ND] = va[i];
            if (i == 2) in_valid[1] = 0;
            cyc();
        end
        idle_inputs();
        rst = 1;
        settle();
        check("t5_rst_ready", in_ready, 0);
        tick();
        rst = 0;
        settle();
        check("t5_valid", out_valid, 0);
        check("t5_ready", in_ready, 8'hFF);
        check("t5_flags", {in_under, out_over}, 0);
        tick();

        // Interleaved writes to out channels 0 and 7.
        proc_out_en = 1;
        for (int i = 0; i < 16; i++) begin
            proc_addr_out = (i % 2 == 1) ? 3'd7 : 3'd0;
            proc_data_out = ND'($urandom);
            out_ready = 8'($urandom) & 8'h81;
            cyc();
        end
        idle_inputs();
        out_ready = '1;
        for (int i = 0; i < 6; i++) cyc();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            proc_addr_in = 3'($urandom); proc_req_in = 1'($urandom);
            proc_addr_out = 3'($urandom); proc_out_en = 1'($urandom);
            proc_data_out = ND'($urandom);
            for (int c = 0; c < NI; c++) in_data[c*ND +: ND] = ND'($urandom);
            in_valid = 8'($urandom); out_ready = 8'($urandom);
            clr_flags = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
